// File: rtl/gp_group_stage_if.sv
// Bundle of the gp_group_stage operand input and group-pair output channels.
// The slave modport is the stage itself; the master modport is whatever
// produces operands and consumes the registered group pairs.
interface gp_group_stage_if #(
    parameter int INPUTSIZE = 32,
    parameter int GROUPSIZE = 4
);
    localparam int TREESIZE = INPUTSIZE / GROUPSIZE;

    logic                    in_valid;
    logic                    in_ready;
    logic [INPUTSIZE-1:0]    src1;
    logic [INPUTSIZE-1:0]    src2;
    logic                    sub;
    logic                    cin;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*TREESIZE-1:0]   gp;
    logic [INPUTSIZE-1:0]    p_bits;
    logic [INPUTSIZE-1:0]    a_out;
    logic [INPUTSIZE-1:0]    b_out;
    logic                    cin_eff;

    modport slave (
        input  in_valid, src1, src2, sub, cin, out_ready,
        output in_ready, out_valid, gp, p_bits, a_out, b_out, cin_eff
    );

    modport master (
        output in_valid, src1, src2, sub, cin, out_ready,
        input  in_ready, out_valid, gp, p_bits, a_out, b_out, cin_eff
    );
endinterface

// File: rtl/gp_group_stage.sv
// gp_group_stage: registered front end of the parallel-prefix adder.
// Prepares the effective operands, computes per-bit generate/propagate,
// reduces them to per-group (G,P) pairs and registers everything behind a
// two-entry skid buffer so in_ready never depends on out_ready.
// Optional macro GP_GROUP_CIN_FOLD_EN folds the carry-in into group 0.
module gp_group_stage #(
    parameter int INPUTSIZE = 32,
    parameter int GROUPSIZE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    gp_group_stage_if.slave   bus
);
    localparam int TREESIZE = INPUTSIZE / GROUPSIZE;
    // Payload layout: {gp, p_bits, a, b_eff, cin_eff}
    localparam int W = 2*TREESIZE + 3*INPUTSIZE + 1;

    logic [INPUTSIZE-1:0]  b_eff;
    logic [INPUTSIZE-1:0]  g_bits;
    logic [INPUTSIZE-1:0]  p_bits_c;
    logic                  cin_eff_c;
    logic [2*TREESIZE-1:0] gp_c;
    logic [W-1:0]          in_data;

    logic [W-1:0] main_data_reg, main_data_next;
    logic [W-1:0] skid_data_reg, skid_data_next;
    logic         main_valid_reg, main_valid_next;
    logic         skid_valid_reg, skid_valid_next;
    logic         in_xfer;
    logic         out_xfer;

    assign b_eff     = bus.sub ? ~bus.src2 : bus.src2;
    assign cin_eff_c = bus.sub | bus.cin;
    assign g_bits    = bus.src1 & b_eff;
    assign p_bits_c  = bus.src1 ^ b_eff;

    genvar gi;
    generate
        for (gi = 0; gi < TREESIZE; gi++) begin : g_group
            logic grp_g;
            logic grp_p;

            // Ripple lookahead across the group; walking LSB upward yields the
            // same G as folding g_top | p_top & G_lower from the MSB down.
            always_comb begin
                grp_g = 1'b0;
                grp_p = 1'b1;
                for (int j = 0; j < GROUPSIZE; j++) begin
                    grp_g = g_bits[gi*GROUPSIZE + j] | (p_bits_c[gi*GROUPSIZE + j] & grp_g);
                    grp_p = grp_p & p_bits_c[gi*GROUPSIZE + j];
                end
            end

            assign gp_c[2*gi] = grp_p;

            if (gi == 0) begin : g_low
`ifdef GP_GROUP_CIN_FOLD_EN
                // Group 0 carries the carry-in so the tree emits true carries.
                assign gp_c[1] = grp_g | (grp_p & cin_eff_c);
`else
                assign gp_c[1] = grp_g;
`endif
            end else begin : g_high
                assign gp_c[2*gi+1] = grp_g;
            end
        end
    endgenerate

    assign in_data  = {gp_c, p_bits_c, bus.src1, b_eff, cin_eff_c};

    // in_ready only looks at the skid occupancy, never at out_ready.
    assign bus.in_ready  = rst_n & ~skid_valid_reg;
    assign bus.out_valid = main_valid_reg;
    assign {bus.gp, bus.p_bits, bus.a_out, bus.b_out, bus.cin_eff} = main_data_reg;

    assign in_xfer  = bus.in_valid & bus.in_ready;
    assign out_xfer = main_valid_reg & bus.out_ready;

    // Main/skid occupancy: main always holds the oldest beat, skid the next.
    always_comb begin
        main_data_next  = main_data_reg;
        main_valid_next = main_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_valid_next = skid_valid_reg;
        if (!main_valid_reg) begin
            if (in_xfer) begin
                main_data_next  = in_data;
                main_valid_next = 1'b1;
            end
        end else if (out_xfer) begin
            if (skid_valid_reg) begin
                main_data_next  = skid_data_reg;
                skid_valid_next = 1'b0;
            end else if (in_xfer) begin
                main_data_next  = in_data;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (in_xfer) begin
            skid_data_next  = in_data;
            skid_valid_next = 1'b1;
        end
    end

    // State registers; reset discards in-flight beats and zeroes the data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_data_reg  <= '0;
            main_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_data_reg  <= main_data_next;
            main_valid_reg <= main_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_valid_reg <= skid_valid_next;
        end
    end
endmodule

// File: tb/tb_gp_group_stage.sv
// Directed testbench for gp_group_stage (32-bit operands, 4-bit groups).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_gp_group_stage;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

`ifdef GP_GROUP_CIN_FOLD_EN
    localparam logic [15:0] EXP_SUB_GP = 16'h5557;
    localparam logic [15:0] EXP_CIN_GP = 16'h0007;
`else
    localparam logic [15:0] EXP_SUB_GP = 16'h5555;
    localparam logic [15:0] EXP_CIN_GP = 16'h0005;
`endif

    gp_group_stage_if #(.INPUTSIZE(32), .GROUPSIZE(4)) bus ();

    gp_group_stage #(.INPUTSIZE(32), .GROUPSIZE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic c);
        bus.in_valid = 1'b1;
        bus.src1     = a;
        bus.src2     = b;
        bus.sub      = s;
        bus.cin      = c;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_beat(32'h0, 32'h0, 1'b0, 1'b0);
        bus.in_valid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
            end
            checks++;
            if (bus.gp !== 16'h0000) begin
                errors++;
                $display("FAIL reset_gp: got %h required 0000", bus.gp);
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_ready: got %b required 0", bus.in_ready);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready: got %b required 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_out_valid: got %b required 0", bus.out_valid);
        end
        $display("txn reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
    endtask

    task automatic test_group_pairs();
        bus.out_ready = 1'b1;
        // 0xF + 0x1: group 0 generates, nothing propagates to the top.
        set_beat(32'h0000000F, 32'h00000001, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_out_valid: got %b required 1", bus.out_valid);
        end
        checks++;
        if (bus.gp !== 16'h0002) begin
            errors++;
            $display("FAIL add_gp: got %h required 0002", bus.gp);
        end
        checks++;
        if (bus.p_bits !== 32'h0000000E) begin
            errors++;
            $display("FAIL add_p_bits: got %h required 0000000e", bus.p_bits);
        end
        checks++;
        if (bus.cin_eff !== 1'b0 || bus.a_out !== 32'h0000000F || bus.b_out !== 32'h00000001) begin
            errors++;
            $display("FAIL add_operands: got cin=%b a=%h b=%h required cin=0 a=0000000f b=00000001",
                     bus.cin_eff, bus.a_out, bus.b_out);
        end
        $display("txn add: gp=%h p=%h", bus.gp, bus.p_bits);
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_out_valid: got %b required 0", bus.out_valid);
        end

        // All-propagate, no generate.
        set_beat(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.gp !== 16'h5555 || bus.p_bits !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL allprop: got gp=%h p=%h required gp=5555 p=ffffffff", bus.gp, bus.p_bits);
        end
        $display("txn allprop: gp=%h p=%h", bus.gp, bus.p_bits);

        // Subtract 5 - 5.
        set_beat(32'h00000005, 32'h00000005, 1'b1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.b_out !== 32'hFFFFFFFA || bus.cin_eff !== 1'b1) begin
            errors++;
            $display("FAIL sub_operands: got b=%h cin=%b required b=fffffffa cin=1", bus.b_out, bus.cin_eff);
        end
        checks++;
        if (bus.gp !== EXP_SUB_GP) begin
            errors++;
            $display("FAIL sub_gp: got %h required %h", bus.gp, EXP_SUB_GP);
        end
        $display("txn sub: gp=%h b=%h cin=%b", bus.gp, bus.b_out, bus.cin_eff);

        // Add with explicit carry-in: 0xF0 + 0x0F, groups 0 and 1 propagate.
        set_beat(32'h000000F0, 32'h0000000F, 1'b0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.gp !== EXP_CIN_GP || bus.cin_eff !== 1'b1 || bus.p_bits !== 32'h000000FF) begin
            errors++;
            $display("FAIL cin_add: got gp=%h cin=%b p=%h required gp=%h cin=1 p=000000ff",
                     bus.gp, bus.cin_eff, bus.p_bits, EXP_CIN_GP);
        end
        $display("txn cin_add: gp=%h cin=%b", bus.gp, bus.cin_eff);
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        set_beat(32'hA0000001, 32'h0, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.a_out !== 32'hA0000001 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: got v=%b a=%h rdy=%b required v=1 a=a0000001 rdy=1",
                     bus.out_valid, bus.a_out, bus.in_ready);
        end
        set_beat(32'hB0000002, 32'h0, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.a_out !== 32'hA0000001) begin
            errors++;
            $display("FAIL bp_second: got rdy=%b a=%h required rdy=0 a=a0000001", bus.in_ready, bus.a_out);
        end
        set_beat(32'hC0000003, 32'h0, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.a_out !== 32'hA0000001 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full_hold: got rdy=%b a=%h v=%b required rdy=0 a=a0000001 v=1",
                     bus.in_ready, bus.a_out, bus.out_valid);
        end
        $display("txn bp_full: rdy=%b a=%h", bus.in_ready, bus.a_out);
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.a_out !== 32'hB0000002 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_b: got a=%h v=%b rdy=%b required a=b0000002 v=1 rdy=1",
                     bus.a_out, bus.out_valid, bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.a_out !== 32'hC0000003 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_c: got a=%h v=%b required a=c0000003 v=1", bus.a_out, bus.out_valid);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got %b required 0", bus.out_valid);
        end
        $display("txn bp_drained: v=%b rdy=%b", bus.out_valid, bus.in_ready);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h11111111;
        vals[1] = 32'h22222222;
        vals[2] = 32'h33333333;
        vals[3] = 32'h44444444;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_beat(vals[i], 32'h00000001, 1'b1, 1'b0);
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.a_out !== vals[i] || bus.b_out !== 32'hFFFFFFFE ||
                bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: got v=%b a=%h b=%h rdy=%b required v=1 a=%h b=fffffffe rdy=1",
                         i, bus.out_valid, bus.a_out, bus.b_out, bus.in_ready, vals[i]);
            end
            $display("txn b2b_%0d: a=%h", i, bus.a_out);
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got %b required 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        set_beat(32'hD0000004, 32'h0, 1'b0, 1'b1);
        step();
        set_beat(32'hE0000005, 32'h0, 1'b0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: got rdy=%b v=%b required rdy=0 v=1", bus.in_ready, bus.out_valid);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.a_out !== 32'h0 || bus.gp !== 16'h0 ||
            bus.p_bits !== 32'h0 || bus.b_out !== 32'h0 || bus.cin_eff !== 1'b0 ||
            bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b a=%h gp=%h p=%h b=%h cin=%b rdy=%b required all zero",
                     bus.out_valid, bus.a_out, bus.gp, bus.p_bits, bus.b_out, bus.cin_eff, bus.in_ready);
        end
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_ghost_%0d: got v=%b a=%h required v=0", i, bus.out_valid, bus.a_out);
            end
        end
        $display("txn reset_midstream: v=%b rdy=%b", bus.out_valid, bus.in_ready);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_group_pairs();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
